// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit (op codes, FSM states, counter sizing).
package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int MULDIV_WIDTH = 32;
   localparam int CNT_W        = $clog2(MULDIV_WIDTH);

   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/muldiv_absneg.sv
// Conditional two's-complement: passes the value through or negates it when asked.
module muldiv_absneg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   assign result = negate ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit producing HI/LO.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiplies leave RUN once the multiplier is exhausted).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             gclk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);

   state_t             state, state_nxt;
   logic [CW-1:0]      count;
   logic               is_div, neg_res, neg_rem, div_zero;
   logic [WIDTH-1:0]   a_raw, shreg;
   logic [2*WIDTH-1:0] acc, mcand;

   logic               sign_a, sign_b, last_step;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix, acc_mul, acc_div;
   logic [WIDTH:0]     rem_shift, rem_diff;

   assign sign_a = op[0] & a[WIDTH-1];
   assign sign_b = op[0] & b[WIDTH-1];

   muldiv_absneg #(.WIDTH(WIDTH))   u_abs_a    (.value(a), .negate(sign_a), .result(a_mag));
   muldiv_absneg #(.WIDTH(WIDTH))   u_abs_b    (.value(b), .negate(sign_b), .result(b_mag));
   muldiv_absneg #(.WIDTH(2*WIDTH)) u_fix_prod (.value(acc), .negate(neg_res), .result(prod_fix));
   muldiv_absneg #(.WIDTH(WIDTH))   u_fix_quo  (.value(acc[WIDTH-1:0]), .negate(neg_res), .result(quo_fix));
   muldiv_absneg #(.WIDTH(WIDTH))   u_fix_rem  (.value(acc[2*WIDTH-1:WIDTH]), .negate(neg_rem), .result(rem_fix));

   // One step of each algorithm; acc holds {remainder, quotient/dividend} when dividing.
   always_comb begin
      acc_mul   = shreg[0] ? (acc + mcand) : acc;
      rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, shreg};
      if (rem_diff[WIDTH])
         acc_div = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_div = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign last_step = (count == '0) || (!is_div && (shreg[WIDTH-1:1] == '0));
`else
   assign last_step = (count == '0);
`endif

   always_ff @(posedge gclk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_step) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Operands are captured as magnitudes; hi/lo only move on the FIN edge.
   always_ff @(posedge gclk or posedge reset) begin
      if (reset) begin
         count       <= '0;
         is_div      <= 1'b0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         div_zero    <= 1'b0;
         a_raw       <= '0;
         shreg       <= '0;
         acc         <= '0;
         mcand       <= '0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  neg_res  <= sign_a ^ sign_b;
                  neg_rem  <= sign_a;
                  div_zero <= op[1] & (b == '0);
                  a_raw    <= a;
                  count    <= CW'(WIDTH-1);
                  shreg    <= b_mag;
                  if (op[1]) begin
                     acc   <= {{WIDTH{1'b0}}, a_mag};
                     mcand <= '0;
                  end else begin
                     acc   <= '0;
                     mcand <= {{WIDTH{1'b0}}, a_mag};
                  end
               end
            end
            RUN: begin
               count <= count - CW'(1);
               if (is_div) begin
                  acc <= acc_div;
               end else begin
                  acc   <= acc_mul;
                  mcand <= mcand << 1;
                  shreg <= shreg >> 1;
               end
            end
            FIN: begin
               done        <= 1'b1;
               div_by_zero <= div_zero;
               if (!is_div) begin
                  {hi, lo} <= prod_fix;
               end else if (div_zero) begin
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus directed vectors.
`timescale 1ns/1ps
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         gclk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   logic         m_busy, m_done, m_dbz, p_dbz;
   logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
   int           m_left;

   always #5 gclk = ~gclk;

   muldiv_unit #(.WIDTH(W)) dut (
      .gclk(gclk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   // Reference result from plain 64-bit arithmetic.
   function automatic void model_result(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                                        output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
      longint       sa, sb, q, r, pr;
      logic [63:0]  pv, qv, rv;
      sa = longint'($signed(va));
      sb = longint'($signed(vb));
      rz = 1'b0;
      if (o[1] && vb == '0) begin
         rh = va;
         rl = '1;
         rz = 1'b1;
      end else if (o == OP_MULTU) begin
         pv = {32'b0, va} * {32'b0, vb};
         rh = pv[63:32];
         rl = pv[31:0];
      end else if (o == OP_MULT) begin
         pr = sa * sb;
         pv = pr;
         rh = pv[63:32];
         rl = pv[31:0];
      end else if (o == OP_DIVU) begin
         rl = va / vb;
         rh = va % vb;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         qv = q;
         rv = r;
         rl = qv[31:0];
         rh = rv[31:0];
      end
   endfunction

   // Number of cycles busy stays high after the accept edge.
   function automatic int busy_len(input logic [1:0] o, input logic [W-1:0] vb);
      logic [W-1:0] mag;
      int k;
      if (o[1] || !EARLY) return W + 1;
      mag = (o == OP_MULT && vb[W-1]) ? -vb : vb;
      k = 1;
      for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
      return k + 1;
   endfunction

   always @(posedge gclk or posedge reset) begin
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
         m_hi = '0; m_lo = '0; m_left = 0;
      end else begin
         m_done = 1'b0;
         m_dbz  = 1'b0;
         if (!m_busy) begin
            if (start) begin
               model_result(op, a, b, p_hi, p_lo, p_dbz);
               m_left = busy_len(op, b);
               m_busy = 1'b1;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_hi   = p_hi;
               m_lo   = p_lo;
               m_dbz  = p_dbz;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge gclk) begin
      if (check_en) begin
         checkOutput("model_busy", W'(busy), W'(m_busy));
         checkOutput("model_done", W'(done), W'(m_done));
         checkOutput("model_dbz", W'(div_by_zero), W'(m_dbz));
         checkOutput("model_hi", hi, m_hi);
         checkOutput("model_lo", lo, m_lo);
      end
   end

   task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
      op    = o;
      a     = va;
      b     = vb;
      start = 1'b1;
   endtask

   // Issue one operation and compare the hand-computed result and latency.
   task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input logic e_dbz, input int e_cyc);
      int cyc;
      bit seen;
      applyStimulus(o, va, vb);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(negedge gclk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            op    = 2'($urandom);
            a     = $urandom;
            b     = $urandom;
            checkOutput({name, "_busy1"}, W'(busy), 1);
         end
         if (done) seen = 1'b1;
      end
      checkOutput({name, "_cycles"}, cyc, e_cyc);
      checkOutput({name, "_hi"}, hi, e_hi);
      checkOutput({name, "_lo"}, lo, e_lo);
      checkOutput({name, "_dbz"}, W'(div_by_zero), W'(e_dbz));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      repeat (2) @(negedge gclk);
      check_en = 1'b1;
      checkOutput("reset_busy", W'(busy), 0);
      checkOutput("reset_done", W'(done), 0);
      checkOutput("reset_hi", hi, 0);
      checkOutput("reset_lo", lo, 0);
      reset = 1'b0;

      runOp("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, EARLY ? 5 : 34);
      runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
      runOp("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
      runOp("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 34);
      runOp("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 34);
      @(negedge gclk);
      checkOutput("divu_by0_pulse_end", W'(div_by_zero), 0);
      runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
      runOp("multu_5x1", OP_MULTU, 32'd5, 32'd1, 32'd0, 32'd5, 1'b0, EARLY ? 3 : 34);

      // A MULT is aborted by reset after an ignored second start.
      applyStimulus(OP_MULT, 32'h10, 32'h20);
      for (cyc = 1; cyc <= 10; cyc++) begin
         @(negedge gclk);
         if (cyc == 1 || cyc == 6) start = 1'b0;
         if (cyc == 5) applyStimulus(OP_DIVU, 32'd100, 32'd3);
         if (cyc == 9) checkOutput("abort_busy9", W'(busy), 1);
      end
      #2 reset = 1'b1;
      @(negedge gclk);
      checkOutput("abort_busy", W'(busy), 0);
      checkOutput("abort_done", W'(done), 0);
      checkOutput("abort_hi", hi, 0);
      checkOutput("abort_lo", lo, 0);
      #2 reset = 1'b0;
      runOp("div_100_neg7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, 34);

      repeat (3) @(negedge gclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
